// File: rtl/pll_clock_gen.sv
`default_nettype none
// ============================================================================
// Module      : pll_clock_gen
// Description : Synthesizable stand-in for the board PLL primitive. Derives
//               four clocks c0..c3 from inclk0 by integer division, each with
//               its own rising-edge phase offset, and raises locked after a
//               fixed number of reference edges following reset release.
//               Optional macro PLL_GATE_UNLOCKED_EN holds every output low
//               until lock; the phase counters keep running so the relative
//               phase of the outputs is preserved.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_clock_gen #(
  parameter int DIV0        = 10,
  parameter int DIV1        = 2,
  parameter int DIV2        = 4,
  parameter int DIV3        = 4,
  parameter int PHASE0      = 0,
  parameter int PHASE1      = 0,
  parameter int PHASE2      = 0,
  parameter int PHASE3      = 1,
  parameter int LOCK_CYCLES = 16
) (
  input  logic inclk0,
  input  logic nreset_in,
  output logic c0,
  output logic c1,
  output logic c2,
  output logic c3,
  output logic locked
);

  // --------------------------------------------------------------------------
  // Lock counter
  // --------------------------------------------------------------------------
  // Width is guarded so an illegal LOCK_CYCLES still elaborates far enough to
  // reach the configuration error below instead of a width error.
  localparam int c_LW = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);
  localparam logic [c_LW-1:0] c_LOCK_TGT = c_LW'(LOCK_CYCLES);

  logic [c_LW-1:0] r_lock_cnt;
  logic [c_LW-1:0] w_lock_cnt_next;
  logic            r_locked;
  logic            w_locked_next;
  logic [3:0]      w_clk;

  if (LOCK_CYCLES < 1) begin : g_bad_lock
    $error("pll_clock_gen: LOCK_CYCLES must be >= 1 (got %0d)", LOCK_CYCLES);
  end

  // Saturating edge count; locked_next is exposed so gated outputs can use
  // the value locked is about to take on this same edge.
  always_comb begin
    w_lock_cnt_next = r_lock_cnt;
    if (r_lock_cnt != c_LOCK_TGT) begin
      w_lock_cnt_next = r_lock_cnt + c_LW'(1);
    end
    w_locked_next = (w_lock_cnt_next == c_LOCK_TGT);
  end

  // Lock state: cleared asynchronously, sticky once reached until next reset.
  always_ff @(posedge inclk0 or negedge nreset_in) begin
    if (!nreset_in) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else begin
      r_lock_cnt <= w_lock_cnt_next;
      r_locked   <= r_locked | w_locked_next;
    end
  end

  // --------------------------------------------------------------------------
  // Divider channels
  // --------------------------------------------------------------------------
  // Each channel runs a modulo-DIV phase counter. The counter is preloaded
  // with (DIV-PHASE) mod DIV so that it wraps to zero exactly PHASE edges
  // after release; the output is high while the counter is in its lower half.
  // All channels start on the same edge, which fixes their phase relation.
  for (genvar gi = 0; gi < 4; gi++) begin : g_ch
    localparam int c_D = (gi == 0) ? DIV0 :
                         (gi == 1) ? DIV1 :
                         (gi == 2) ? DIV2 : DIV3;
    localparam int c_P = (gi == 0) ? PHASE0 :
                         (gi == 1) ? PHASE1 :
                         (gi == 2) ? PHASE2 : PHASE3;
    localparam bit c_BAD  = (c_D < 2) || (c_P < 0) || (c_P >= c_D);
    localparam int c_W    = (c_D < 2) ? 1 : $clog2(c_D);
    localparam int c_INIT = c_BAD ? 0 : ((c_D - c_P) % c_D);
    localparam int c_LAST_I = c_BAD ? 0 : (c_D - 1);
    localparam int c_HALF_I = c_BAD ? 0 : (c_D / 2);

    localparam logic [c_W-1:0] c_INIT_V = c_W'(c_INIT);
    localparam logic [c_W-1:0] c_LAST   = c_W'(c_LAST_I);
    localparam logic [c_W-1:0] c_HALF   = c_W'(c_HALF_I);

    if (c_BAD) begin : g_bad_cfg
      $error("pll_clock_gen: channel %0d needs DIV >= 2 and 0 <= PHASE < DIV (DIV=%0d PHASE=%0d)",
             gi, c_D, c_P);
    end

    logic [c_W-1:0] r_pcnt;
    logic           r_clk;
    logic           w_high;
    logic           w_clk_next;

    assign w_high = (r_pcnt < c_HALF);

`ifdef PLL_GATE_UNLOCKED_EN
    // Outputs held low until the edge on which lock is reached.
    assign w_clk_next = w_locked_next & w_high;
`else
    // Outputs free-run from the first edge; lock is informational only.
    assign w_clk_next = w_high;
`endif

    // Phase counter and registered (glitch-free) divided clock.
    always_ff @(posedge inclk0 or negedge nreset_in) begin
      if (!nreset_in) begin
        r_pcnt <= c_INIT_V;
        r_clk  <= 1'b0;
      end else begin
        r_pcnt <= (r_pcnt == c_LAST) ? '0 : (r_pcnt + c_W'(1));
        r_clk  <= w_clk_next;
      end
    end

    assign w_clk[gi] = r_clk;
  end

  assign c0     = w_clk[0];
  assign c1     = w_clk[1];
  assign c2     = w_clk[2];
  assign c3     = w_clk[3];
  assign locked = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_pll_clock_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_clock_gen
// Description : Self-checking bench for pll_clock_gen. Two instances share
//               clock and reset: A with default parameters, B with odd and
//               offset dividers (DIV2=3, PHASE2=0 among them). Expected outputs
//               come from an edge-number model: channel high when
//               (edge-1-PHASE) mod DIV < DIV/2, locked once edge >= LOCK_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_clock_gen;

  // Instance parameters, also used by the reference model.
  localparam int c_DIV_A [4] = '{10, 2, 4, 4};
  localparam int c_PH_A  [4] = '{0, 0, 0, 1};
  localparam int c_LOCK_A    = 16;
  localparam int c_DIV_B [4] = '{7, 5, 3, 6};
  localparam int c_PH_B  [4] = '{3, 4, 0, 5};
  localparam int c_LOCK_B    = 5;

  logic inclk0;
  logic nreset_in;
  logic a_c0, a_c1, a_c2, a_c3, a_locked;
  logic b_c0, b_c1, b_c2, b_c3, b_locked;

  int n_cmp;
  int n_bad;
  int edge_no;   // edges since last reset release; 0 while in reset

  pll_clock_gen u_dut_a (
    .inclk0    (inclk0),
    .nreset_in (nreset_in),
    .c0        (a_c0),
    .c1        (a_c1),
    .c2        (a_c2),
    .c3        (a_c3),
    .locked    (a_locked)
  );

  pll_clock_gen #(
    .DIV0(7), .DIV1(5), .DIV2(3), .DIV3(6),
    .PHASE0(3), .PHASE1(4), .PHASE2(0), .PHASE3(5),
    .LOCK_CYCLES(5)
  ) u_dut_b (
    .inclk0    (inclk0),
    .nreset_in (nreset_in),
    .c0        (b_c0),
    .c1        (b_c1),
    .c2        (b_c2),
    .c3        (b_c3),
    .locked    (b_locked)
  );

  initial inclk0 = 1'b0;
  always #5 inclk0 = ~inclk0;

  // Expected {locked, c3, c2, c1, c0} after edge e for instance s (0=A, 1=B).
  function automatic logic [4:0] model_vec(input int s, input int e);
    logic [4:0] v;
    int d;
    int p;
    bit lk;
    bit hi;
    v = '0;
    if (e < 1) return v;
    lk = (e >= ((s == 0) ? c_LOCK_A : c_LOCK_B));
    for (int ch = 0; ch < 4; ch++) begin
      d  = (s == 0) ? c_DIV_A[ch] : c_DIV_B[ch];
      p  = (s == 0) ? c_PH_A[ch]  : c_PH_B[ch];
      hi = (((e - 1 - p + d) % d) < (d / 2));
`ifdef PLL_GATE_UNLOCKED_EN
      hi = hi & lk;
`endif
      v[ch] = hi;
    end
    v[4] = lk;
    return v;
  endfunction

  function automatic logic [4:0] act_vec(input int s);
    if (s == 0) return {a_locked, a_c3, a_c2, a_c1, a_c0};
    return {b_locked, b_c3, b_c2, b_c1, b_c0};
  endfunction

  // Release between edges; the next rising edge is edge 1.
  task automatic release_reset();
    @(negedge inclk0);
    nreset_in = 1'b1;
    edge_no   = 0;
  endtask

  // Reset held with the clock running: everything must stay zero.
  task automatic test_reset();
    logic [4:0] act;
    nreset_in = 1'b0;
    edge_no   = 0;
    repeat (20) begin
      @(posedge inclk0);
      #1;
      for (int s = 0; s < 2; s++) begin
        act = act_vec(s);
        n_cmp++;
        if (act !== 5'b0) begin
          n_bad++;
          $display("FAIL reset_hold dut%0d t=%0t actual=%b required=%b", s, $time, act, 5'b0);
        end
      end
    end
  endtask

  // Free run from release through edge 37 (covers lock at edge 16).
  task automatic test_defaults();
    logic [4:0] act;
    logic [4:0] exp;
    release_reset();
    repeat (37) begin
      @(posedge inclk0);
      edge_no++;
      #1;
      for (int s = 0; s < 2; s++) begin
        act = act_vec(s);
        exp = model_vec(s, edge_no);
        n_cmp++;
        if (act !== exp) begin
          n_bad++;
          $display("FAIL run_defaults dut%0d edge=%0d actual=%b required=%b", s, edge_no, act, exp);
        end
      end
    end
  endtask

  // Asynchronous reset between edges, then restart from edge 1.
  task automatic test_mid_reset();
    logic [4:0] act;
    logic [4:0] exp;
    #3;
    nreset_in = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      act = act_vec(s);
      n_cmp++;
      if (act !== 5'b0) begin
        n_bad++;
        $display("FAIL async_reset dut%0d t=%0t actual=%b required=%b", s, $time, act, 5'b0);
      end
    end
    repeat (2) @(posedge inclk0);
    release_reset();
    repeat (24) begin
      @(posedge inclk0);
      edge_no++;
      #1;
      for (int s = 0; s < 2; s++) begin
        act = act_vec(s);
        exp = model_vec(s, edge_no);
        n_cmp++;
        if (act !== exp) begin
          n_bad++;
          $display("FAIL restart dut%0d edge=%0d actual=%b required=%b", s, edge_no, act, exp);
        end
      end
    end
  endtask

  // Random run lengths and random reset instants within the clock period.
  task automatic test_random();
    logic [4:0] act;
    logic [4:0] exp;
    int run_len;
    int hold;
    for (int it = 0; it < 8; it++) begin
      run_len = $urandom_range(1, 45);
      repeat (run_len) begin
        @(posedge inclk0);
        edge_no++;
        #1;
        for (int s = 0; s < 2; s++) begin
          act = act_vec(s);
          exp = model_vec(s, edge_no);
          n_cmp++;
          if (act !== exp) begin
            n_bad++;
            $display("FAIL random_run it=%0d dut%0d edge=%0d actual=%b required=%b",
                     it, s, edge_no, act, exp);
          end
        end
      end
      // Now 1 time unit after an edge; next edge is 9 units away.
      #($urandom_range(1, 7));
      nreset_in = 1'b0;
      #1;
      for (int s = 0; s < 2; s++) begin
        act = act_vec(s);
        n_cmp++;
        if (act !== 5'b0) begin
          n_bad++;
          $display("FAIL random_async_reset it=%0d dut%0d actual=%b required=%b", it, s, act, 5'b0);
        end
      end
      hold = $urandom_range(0, 3);
      repeat (hold) begin
        @(posedge inclk0);
        #1;
        for (int s = 0; s < 2; s++) begin
          act = act_vec(s);
          n_cmp++;
          if (act !== 5'b0) begin
            n_bad++;
            $display("FAIL random_reset_hold it=%0d dut%0d actual=%b required=%b", it, s, act, 5'b0);
          end
        end
      end
      release_reset();
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    edge_no   = 0;
    nreset_in = 1'b0;
    test_reset();
    test_defaults();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
